// File: rtl/core_pkg.sv
// core_pkg: definitions shared by the execute and memory stages.
//   - mem_state_e : memory-stage state encoding
//   - REG_PC/REG_SF : register indices that execute treats specially
//   - BE_* : byte-lane enables for the 16-bit external bus
//            (bit 0 = even byte on bits 7:0, bit 1 = odd byte on bits 15:8)
package core_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        BUS2 = 2'd2,
        RESP = 2'd3
    } mem_state_e;

    localparam logic [2:0] REG_PC = 3'd3;
    localparam logic [2:0] REG_SF = 3'd2;

    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;
    localparam logic [1:0] BE_WORD = 2'b11;

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane steering for one bus cycle.
//   byte_acc   : 1 = single-byte cycle, 0 = full word
//   lane_hi    : byte cycles only, selects the odd lane (bits 15:8)
//   wdata      : store data; a byte store takes bits 7:0
//   rdata      : raw bus read data
//   be         : lane enables for this cycle
//   lane_wdata : store data on the bus (a byte is replicated to both lanes)
//   load_data  : a byte load is zero-extended from the selected lane;
//                a word load passes through (little-endian)
module mem_lane_align
    import core_pkg::*;
(
    input  logic        byte_acc,
    input  logic        lane_hi,
    input  logic [15:0] wdata,
    input  logic [15:0] rdata,
    output logic [1:0]  be,
    output logic [15:0] lane_wdata,
    output logic [15:0] load_data
);

    always_comb begin
        be         = BE_WORD;
        lane_wdata = wdata;
        load_data  = rdata;
        if (byte_acc) begin
            be         = lane_hi ? BE_HI : BE_LO;
            lane_wdata = {wdata[7:0], wdata[7:0]};
            load_data  = {8'h00, (lane_hi ? rdata[15:8] : rdata[7:0])};
        end
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage behind execute. Accepts one load/store,
// runs it on the 16-bit external bus and reports completion to writeback.
//   req_*  : request from execute (valid/ready handshake, ready only in IDLE)
//   bus_*  : external bus; bus_req held with stable fields until bus_ack
//   wb_*   : one-cycle completion pulse; wb_we set only for clean loads
//   fault  : sticky timeout/alignment fault, cleared by reset only
// Build option MEM_STAGE_UNALIGNED_EN: an odd-address word access is split
// into two byte cycles (low byte at addr's word on lane 1, high byte at the
// next word on lane 0). Without it, such an access faults with no bus cycle.
module mem_stage
    import core_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int ADDR_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_byte,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_wdata,
    input  logic [2:0]        req_dst,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-2:0] bus_addr,
    output logic [1:0]        bus_be,
    output logic [15:0]       bus_wdata,
    input  logic [15:0]       bus_rdata,
    input  logic              bus_ack,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [2:0]        wb_idx,
    output logic [15:0]       wb_data,
    output logic              fault
);

`ifdef MEM_STAGE_UNALIGNED_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    mem_state_e state, state_nx;

    // Latched transaction; byte_q/hi_q/wdata_q/addr_q describe the bus
    // cycle currently in flight and are rewritten between split halves.
    logic              we_q, byte_q, hi_q, split_q, err_q, fault_q;
    logic [ADDR_W-2:0] addr_q;
    logic [15:0]       wdata_q, wb_data_q;
    logic [7:0]        lo_q;          // low byte from the first split half
    logic [2:0]        dst_q;
    logic [15:0]       tmo_cnt;

    logic              misalign, tmo_hit;
    logic [1:0]        lane_be;
    logic [15:0]       lane_wdata, lane_load;

    assign misalign = ~req_byte & req_addr[0];
    assign tmo_hit  = (TIMEOUT != 0) && (int'(tmo_cnt) == TIMEOUT - 1);

    mem_lane_align u_align (
        .byte_acc  (byte_q),
        .lane_hi   (hi_q),
        .wdata     (wdata_q),
        .rdata     (bus_rdata),
        .be        (lane_be),
        .lane_wdata(lane_wdata),
        .load_data (lane_load)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (req_valid) state_nx = (misalign && !SPLIT_EN) ? RESP : BUS;
            // bus_ack is checked first so an ack on the expiry cycle wins
            BUS: begin
                if (bus_ack)      state_nx = split_q ? BUS2 : RESP;
                else if (tmo_hit) state_nx = RESP;
            end
            BUS2: if (bus_ack || tmo_hit) state_nx = RESP;
            RESP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            byte_q    <= 1'b0;
            hi_q      <= 1'b0;
            split_q   <= 1'b0;
            err_q     <= 1'b0;
            fault_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wb_data_q <= '0;
            lo_q      <= '0;
            dst_q     <= '0;
            tmo_cnt   <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (req_valid) begin
                    we_q      <= req_we;
                    dst_q     <= req_dst;
                    wdata_q   <= req_wdata;
                    addr_q    <= req_addr[ADDR_W-1:1];
                    hi_q      <= req_addr[0];
                    split_q   <= SPLIT_EN & misalign;
                    byte_q    <= req_byte | (SPLIT_EN & misalign);
                    err_q     <= misalign & ~SPLIT_EN;
                    fault_q   <= fault_q | (misalign & ~SPLIT_EN);
                    tmo_cnt   <= '0;
                    wb_data_q <= '0;
                end
                BUS, BUS2: begin
                    if (bus_ack) begin
                        if (state == BUS && split_q) begin
                            // second half: next word (wraps), even lane, high byte
                            lo_q    <= lane_load[7:0];
                            hi_q    <= 1'b0;
                            addr_q  <= addr_q + 1'b1;
                            wdata_q <= {8'h00, wdata_q[15:8]};
                            tmo_cnt <= '0;
                        end else if (!we_q) begin
                            wb_data_q <= split_q ? {lane_load[7:0], lo_q} : lane_load;
                        end
                    end else if (tmo_hit) begin
                        err_q     <= 1'b1;
                        fault_q   <= 1'b1;
                        wb_data_q <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (state == IDLE);
    assign bus_req   = (state == BUS) || (state == BUS2);
    assign bus_we    = bus_req & we_q;
    assign bus_be    = bus_req ? lane_be : 2'b00;
    assign bus_addr  = addr_q;
    assign bus_wdata = lane_wdata;
    assign wb_valid  = (state == RESP);
    assign wb_we     = wb_valid & ~we_q & ~err_q;
    assign wb_idx    = dst_q;
    assign wb_data   = wb_data_q;
    assign fault     = fault_q;

endmodule
